// File: rtl/mem_data_dumper.sv
// Streams data memory words 0..DUMP_DEPTH-1 to the UART TX, high byte first, one start/done handshake per byte.
// Define DUMP_CHECKSUM_EN to append one trailing byte: the XOR of every byte sent in the dump.
module mem_data_dumper #(
  parameter int RAM_WIDTH    = 16,
  parameter int ADDR_WIDTH   = 11,
  parameter int DUMP_DEPTH   = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [RAM_WIDTH-1:0]  i_mem_data,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_start,
  input  logic                  i_tx_done,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(READ_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DUMP_DEPTH - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_LATCH,
    S_SEND_HI,
    S_WAIT_HI,
    S_SEND_LO,
    S_WAIT_LO,
    S_NEXT,
`ifdef DUMP_CHECKSUM_EN
    S_SEND_CK,
    S_WAIT_CK,
`endif
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic [RAM_WIDTH-1:0]    word_q, word_d;
  logic [7:0]              hi_byte, lo_byte;

  assign hi_byte    = word_q[RAM_WIDTH-1 -: 8];
  assign lo_byte    = word_q[7:0];
  assign o_mem_addr = addr_q;

`ifdef DUMP_CHECKSUM_EN
  logic [7:0] ck_q, ck_d;

  always_comb begin
    ck_d = ck_q;
    if (state_q == S_IDLE && i_start) begin
      ck_d = '0;
    end else if (state_q == S_SEND_HI) begin
      ck_d = ck_q ^ hi_byte;
    end else if (state_q == S_SEND_LO) begin
      ck_d = ck_q ^ lo_byte;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ck_q <= '0;
    end else begin
      ck_q <= ck_d;
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wait_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wait_q  <= wait_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wait_d     = wait_q;
    word_d     = word_q;
    o_tx_data  = '0;
    o_tx_start = 1'b0;
    o_done     = 1'b0;
    o_busy     = 1'b1;
    case (state_q)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          addr_d  = '0;
          wait_d  = '0;
          state_d = S_ADDR;
        end
      end
      // The address is already stable here; stay until the memory pipeline delivers it.
      S_ADDR: begin
        if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = S_LATCH;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_LATCH: begin
        word_d  = i_mem_data;
        state_d = S_SEND_HI;
      end
      S_SEND_HI: begin
        o_tx_data  = hi_byte;
        o_tx_start = 1'b1;
        state_d    = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        o_tx_data = hi_byte;
        if (i_tx_done) begin
          state_d = S_SEND_LO;
        end
      end
      S_SEND_LO: begin
        o_tx_data  = lo_byte;
        o_tx_start = 1'b1;
        state_d    = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        o_tx_data = lo_byte;
        if (i_tx_done) begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (addr_q == LAST_ADDR) begin
`ifdef DUMP_CHECKSUM_EN
          state_d = S_SEND_CK;
`else
          state_d = S_DONE;
`endif
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = S_ADDR;
        end
      end
`ifdef DUMP_CHECKSUM_EN
      S_SEND_CK: begin
        o_tx_data  = ck_q;
        o_tx_start = 1'b1;
        state_d    = S_WAIT_CK;
      end
      S_WAIT_CK: begin
        o_tx_data = ck_q;
        if (i_tx_done) begin
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        o_busy  = 1'b0;
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
